ex_mem_stage: RTL and testbench

- Execute stage plus EX/MEM pipeline register of the 64-bit RISC-V 5-stage pipeline.
- Consumes the registered ID/EX bundle: PC, operands, immediate, funct, rd and control.
- Computes the ALU result and branch decision, then registers everything for the MEM stage.
- Squashes wrong-path instructions after a taken branch, and supports stall (hold) and flush (bubble).

---
 rtl/ex_mem_stage.sv | 192 +++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM pipeline register for a 64-bit RISC-V 5-stage pipeline.
// All state updates happen on the falling edge of clk. A small FSM squashes wrong-path captures after a taken branch.
module ex_mem_stage #(
    parameter int XLEN         = 64,
    parameter int SQUASH_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            valid_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] readdata1,
    input  logic [XLEN-1:0] readdata2,
    input  logic [XLEN-1:0] immgen_val,
    input  logic [3:0]      funct_in,
    input  logic [4:0]      rd_in,
    input  logic            MemtoReg,
    input  logic            RegWrite,
    input  logic            Branch,
    input  logic            MemWrite,
    input  logic            MemRead,
    input  logic            ALUsrc,
    input  logic [1:0]      ALU_op,
    output logic [XLEN-1:0] alu_result_store,
    output logic [XLEN-1:0] writedata_store,
    output logic [4:0]      rd_store,
    output logic            MemtoReg_store,
    output logic            RegWrite_store,
    output logic            MemWrite_store,
    output logic            MemRead_store,
    output logic            valid_store,
    output logic [XLEN-1:0] branch_target,
    output logic            pc_src,
    output logic            squashing
);

    localparam int          SHW   = $clog2(XLEN);
    localparam logic [1:0]  DEPTH = 2'(SQUASH_DEPTH);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] alu_result_store_q, alu_result_store_d;
    logic [XLEN-1:0] writedata_store_q, writedata_store_d;
    logic [4:0]      rd_store_q, rd_store_d;
    logic            MemtoReg_store_q, MemtoReg_store_d;
    logic            RegWrite_store_q, RegWrite_store_d;
    logic            MemWrite_store_q, MemWrite_store_d;
    logic            MemRead_store_q, MemRead_store_d;
    logic            valid_store_q, valid_store_d;
    logic [XLEN-1:0] branch_target_q, branch_target_d;
    logic            pc_src_q, pc_src_d;

    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] diff;
    logic [SHW-1:0]  shamt;
    logic [3:0]      eff_funct;
    logic [XLEN-1:0] alu_out;
    logic            br_cond;
    logic            capture;
    logic            live;
    logic            taken;

    // ALU and branch comparator
    always_comb begin
        op_b      = ALUsrc ? immgen_val : readdata2;
        diff      = readdata1 - op_b;
        shamt     = op_b[SHW-1:0];
        eff_funct = funct_in;
        // I-type only uses funct7[5] to pick srai over srli
        if (ALU_op == 2'b11 && funct_in[2:0] != 3'b101) begin
            eff_funct = {1'b0, funct_in[2:0]};
        end
        alu_out = '0;
        case (ALU_op)
            2'b00: alu_out = readdata1 + op_b;
            2'b01: alu_out = diff;
            default: begin
                case (eff_funct)
                    4'b0000: alu_out = readdata1 + op_b;
                    4'b1000: alu_out = diff;
                    4'b0111: alu_out = readdata1 & op_b;
                    4'b0110: alu_out = readdata1 | op_b;
                    4'b0100: alu_out = readdata1 ^ op_b;
                    4'b0001: alu_out = readdata1 << shamt;
                    4'b0101: alu_out = readdata1 >> shamt;
                    4'b1101: alu_out = $signed(readdata1) >>> shamt;
                    default: alu_out = '0;
                endcase
            end
        endcase
        br_cond = 1'b0;
        case (funct_in[2:0])
            3'b000:  br_cond = (diff == '0);
            3'b001:  br_cond = (diff != '0);
            3'b100:  br_cond = ($signed(readdata1) < $signed(op_b));
            3'b101:  br_cond = ($signed(readdata1) >= $signed(op_b));
            default: br_cond = 1'b0;
        endcase
    end

    // Pipeline register load, kill and squash FSM next state
    always_comb begin
        capture = !stall || flush;
        live    = valid_in && !flush && (state_q == RUN);
        taken   = live && Branch && br_cond;

        state_d            = state_q;
        cnt_d              = cnt_q;
        alu_result_store_d = alu_result_store_q;
        writedata_store_d  = writedata_store_q;
        rd_store_d         = rd_store_q;
        MemtoReg_store_d   = MemtoReg_store_q;
        RegWrite_store_d   = RegWrite_store_q;
        MemWrite_store_d   = MemWrite_store_q;
        MemRead_store_d    = MemRead_store_q;
        valid_store_d      = valid_store_q;
        branch_target_d    = branch_target_q;
        pc_src_d           = pc_src_q;

        if (capture) begin
            alu_result_store_d = alu_out;
            writedata_store_d  = readdata2;
            rd_store_d         = rd_in;
            MemtoReg_store_d   = MemtoReg;
            RegWrite_store_d   = live && RegWrite;
            MemWrite_store_d   = live && MemWrite;
            MemRead_store_d    = live && MemRead;
            valid_store_d      = live;
            branch_target_d    = pc_in + (immgen_val << 1);
            pc_src_d           = taken;

            if (state_q == SQUASH) begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = RUN;
                end
            end else if (taken) begin
                state_d = SQUASH;
                cnt_d   = DEPTH;
            end
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= RUN;
            cnt_q              <= '0;
            alu_result_store_q <= '0;
            writedata_store_q  <= '0;
            rd_store_q         <= '0;
            MemtoReg_store_q   <= 1'b0;
            RegWrite_store_q   <= 1'b0;
            MemWrite_store_q   <= 1'b0;
            MemRead_store_q    <= 1'b0;
            valid_store_q      <= 1'b0;
            branch_target_q    <= '0;
            pc_src_q           <= 1'b0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            alu_result_store_q <= alu_result_store_d;
            writedata_store_q  <= writedata_store_d;
            rd_store_q         <= rd_store_d;
            MemtoReg_store_q   <= MemtoReg_store_d;
            RegWrite_store_q   <= RegWrite_store_d;
            MemWrite_store_q   <= MemWrite_store_d;
            MemRead_store_q    <= MemRead_store_d;
            valid_store_q      <= valid_store_d;
            branch_target_q    <= branch_target_d;
            pc_src_q           <= pc_src_d;
        end
    end

    assign alu_result_store = alu_result_store_q;
    assign writedata_store  = writedata_store_q;
    assign rd_store         = rd_store_q;
    assign MemtoReg_store   = MemtoReg_store_q;
    assign RegWrite_store   = RegWrite_store_q;
    assign MemWrite_store   = MemWrite_store_q;
    assign MemRead_store    = MemRead_store_q;
    assign valid_store      = valid_store_q;
    assign branch_target    = branch_target_q;
    assign pc_src           = pc_src_q;
    assign squashing        = (state_q != RUN);

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: a reference model of the execute/EX-MEM rules checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_ex_mem_stage;

    localparam int XLEN = 64;
    localparam int SQUASH_DEPTH = 2;

    logic            clk;
    logic            rst_n;
    logic            stall;
    logic            flush;
    logic            valid_in;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] readdata1;
    logic [XLEN-1:0] readdata2;
    logic [XLEN-1:0] immgen_val;
    logic [3:0]      funct_in;
    logic [4:0]      rd_in;
    logic            MemtoReg, RegWrite, Branch, MemWrite, MemRead, ALUsrc;
    logic [1:0]      ALU_op;
    logic [XLEN-1:0] alu_result_store;
    logic [XLEN-1:0] writedata_store;
    logic [4:0]      rd_store;
    logic            MemtoReg_store, RegWrite_store, MemWrite_store, MemRead_store;
    logic            valid_store;
    logic [XLEN-1:0] branch_target;
    logic            pc_src;
    logic            squashing;

    int n_pass  = 0;
    int n_total = 0;

    ex_mem_stage #(.XLEN(XLEN), .SQUASH_DEPTH(SQUASH_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
        .pc_in(pc_in), .readdata1(readdata1), .readdata2(readdata2), .immgen_val(immgen_val),
        .funct_in(funct_in), .rd_in(rd_in), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .Branch(Branch), .MemWrite(MemWrite), .MemRead(MemRead), .ALUsrc(ALUsrc),
        .ALU_op(ALU_op), .alu_result_store(alu_result_store), .writedata_store(writedata_store),
        .rd_store(rd_store), .MemtoReg_store(MemtoReg_store), .RegWrite_store(RegWrite_store),
        .MemWrite_store(MemWrite_store), .MemRead_store(MemRead_store), .valid_store(valid_store),
        .branch_target(branch_target), .pc_src(pc_src), .squashing(squashing)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // reference model
    function automatic logic [63:0] m_rop(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b);
        int sh;
        sh = int'(b[5:0]);
        case (f)
            4'd0:    return a + b;
            4'd8:    return a - b;
            4'd7:    return a & b;
            4'd6:    return a | b;
            4'd4:    return a ^ b;
            4'd1:    return a << sh;
            4'd5:    return a >> sh;
            4'd13:   return 64'($signed(a) >>> sh);
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] m_alu(input logic [1:0] op, input logic [3:0] f,
                                          input logic [63:0] a, input logic [63:0] b);
        if (op == 2'd0) return a + b;
        if (op == 2'd1) return a - b;
        if (op == 2'd2) return m_rop(f, a, b);
        if (f[2:0] == 3'b101) return m_rop(f, a, b);
        return m_rop({1'b0, f[2:0]}, a, b);
    endfunction

    function automatic bit m_cond(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
        longint sa, sb;
        sa = a;
        sb = b;
        case (f)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            default: return 1'b0;
        endcase
    endfunction

    logic [63:0] e_alu = '0, e_wd = '0, e_tgt = '0;
    logic [4:0]  e_rd = '0;
    bit e_m2r = 0, e_rw = 0, e_mw = 0, e_mr = 0, e_valid = 0, e_pcsrc = 0;
    int sq_left = 0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_alu = '0; e_wd = '0; e_tgt = '0; e_rd = '0;
            e_m2r = 0; e_rw = 0; e_mw = 0; e_mr = 0; e_valid = 0; e_pcsrc = 0;
            sq_left = 0;
        end else if (!(stall && !flush)) begin
            logic [63:0] b;
            bit live;
            b = ALUsrc ? immgen_val : readdata2;
            live = valid_in && !flush && (sq_left == 0);
            e_alu   = m_alu(ALU_op, funct_in, readdata1, b);
            e_wd    = readdata2;
            e_rd    = rd_in;
            e_m2r   = MemtoReg;
            e_tgt   = pc_in + immgen_val * 2;
            e_valid = live;
            e_rw    = live && RegWrite;
            e_mw    = live && MemWrite;
            e_mr    = live && MemRead;
            e_pcsrc = live && Branch && m_cond(funct_in[2:0], readdata1, b);
            if (sq_left > 0) sq_left--;
            else if (e_pcsrc) sq_left = SQUASH_DEPTH;
        end
    end

    // per-cycle compare, away from the falling (active) edge
    always @(posedge clk) begin
        check("valid_store", valid_store, e_valid);
        check("RegWrite_store", RegWrite_store, e_rw);
        check("MemWrite_store", MemWrite_store, e_mw);
        check("MemRead_store", MemRead_store, e_mr);
        check("pc_src", pc_src, e_pcsrc);
        check("branch_target", branch_target, e_tgt);
        check("squashing", squashing, sq_left > 0);
        if (e_valid) begin
            check("alu_result_store", alu_result_store, e_alu);
            check("writedata_store", writedata_store, e_wd);
            check("rd_store", rd_store, e_rd);
            check("MemtoReg_store", MemtoReg_store, e_m2r);
        end
    end

    // driver tasks
    task automatic nop();
        valid_in = 0; pc_in = '0; readdata1 = '0; readdata2 = '0; immgen_val = '0;
        funct_in = '0; rd_in = '0; MemtoReg = 0; RegWrite = 0; Branch = 0;
        MemWrite = 0; MemRead = 0; ALUsrc = 0; ALU_op = 2'd0;
    endtask

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic rtype(input logic [1:0] op, input logic [3:0] f, input logic [63:0] a,
                         input logic [63:0] b, input bit src, input logic [63:0] imm);
        nop();
        valid_in = 1; ALU_op = op; funct_in = f; readdata1 = a; readdata2 = b;
        ALUsrc = src; immgen_val = imm; RegWrite = 1; rd_in = 5'd5;
    endtask

    task automatic branch(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] pc, input logic [63:0] imm);
        nop();
        valid_in = 1; Branch = 1; ALU_op = 2'd1; funct_in = {1'b0, f};
        readdata1 = a; readdata2 = b; pc_in = pc; immgen_val = imm;
    endtask

    initial begin
        rst_n = 1; stall = 0; flush = 0;
        nop();
        #1 rst_n = 0;
        #1;
        check("reset alu_result_store", alu_result_store, 64'd0);
        check("reset valid_store", valid_store, 64'd0);
        check("reset squashing", squashing, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;

        // add x5 = 7 + 5, then reset between edges
        rtype(2'd2, 4'b0000, 64'd7, 64'd5, 0, 64'd0);
        tick();
        check("add result", alu_result_store, 64'd12);
        check("add rd", rd_store, 64'd5);
        check("add RegWrite", RegWrite_store, 64'd1);
        rst_n = 0;
        #1;
        check("midreset alu", alu_result_store, 64'd0);
        check("midreset RegWrite", RegWrite_store, 64'd0);
        check("midreset rd", rd_store, 64'd0);
        check("midreset valid", valid_store, 64'd0);
        check("midreset squashing", squashing, 64'd0);
        #1 rst_n = 1;
        nop();
        tick();

        // shifts and decode
        rtype(2'd2, 4'b1101, 64'h8000_0000_0000_0010, 64'd4, 0, 64'd0);
        tick();
        check("sra", alu_result_store, 64'hF800_0000_0000_0001);
        rtype(2'd3, 4'b1101, 64'h8000_0000_0000_0010, 64'd999, 1, 64'd4);
        tick();
        check("srai", alu_result_store, 64'hF800_0000_0000_0001);
        rtype(2'd3, 4'b0101, 64'h8000_0000_0000_0010, 64'd0, 1, 64'd4);
        tick();
        check("srli", alu_result_store, 64'h0800_0000_0000_0001);
        rtype(2'd3, 4'b1000, 64'd10, 64'd0, 1, 64'd3);
        tick();
        check("I-type sub code adds", alu_result_store, 64'd13);
        rtype(2'd2, 4'b1000, 64'd10, 64'd3, 0, 64'd0);
        tick();
        check("sub", alu_result_store, 64'd7);
        rtype(2'd2, 4'b0010, 64'd10, 64'd3, 0, 64'd0);
        tick();
        check("unknown funct", alu_result_store, 64'd0);
        rtype(2'd2, 4'b0001, 64'd1, 64'd67, 0, 64'd0);
        tick();
        check("sll uses B[5:0]", alu_result_store, 64'd8);

        // taken beq and two squashed captures
        branch(3'b000, 64'd3, 64'd3, 64'h100, 64'h8);
        tick();
        check("beq pc_src", pc_src, 64'd1);
        check("beq target", branch_target, 64'h110);
        check("beq squashing", squashing, 64'd1);
        rtype(2'd2, 4'b0000, 64'd1, 64'd1, 0, 64'd0);
        tick();
        check("squash1 valid", valid_store, 64'd0);
        check("squash1 RegWrite", RegWrite_store, 64'd0);
        check("squash1 pc_src", pc_src, 64'd0);
        check("squash1 squashing", squashing, 64'd1);
        tick();
        check("squash2 valid", valid_store, 64'd0);
        check("squash2 RegWrite", RegWrite_store, 64'd0);
        check("squash2 squashing", squashing, 64'd0);
        tick();
        check("post-squash valid", valid_store, 64'd1);
        check("post-squash result", alu_result_store, 64'd2);

        // not-taken bne, taken signed blt
        branch(3'b001, 64'd9, 64'd9, 64'h200, 64'h10);
        tick();
        check("bne pc_src", pc_src, 64'd0);
        branch(3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h200, 64'h10);
        tick();
        check("blt pc_src", pc_src, 64'd1);
        check("blt target", branch_target, 64'h220);
        nop();
        tick();
        tick();

        // stall during squash
        branch(3'b101, 64'd5, 64'd2, 64'h300, 64'h4);
        tick();
        check("bge pc_src", pc_src, 64'd1);
        rtype(2'd2, 4'b0110, 64'h0F, 64'hF0, 0, 64'd0);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stalled pc_src", pc_src, 64'd1);
            check("stalled squashing", squashing, 64'd1);
            check("stalled target", branch_target, 64'h308);
        end
        stall = 0;
        tick();
        check("unstall kill1", valid_store, 64'd0);
        tick();
        check("unstall kill2", valid_store, 64'd0);
        tick();
        check("unstall live", valid_store, 64'd1);
        check("or result", alu_result_store, 64'hFF);

        // flush overrides stall
        nop();
        valid_in = 1; ALU_op = 2'd0; ALUsrc = 1; readdata1 = 64'h1000; immgen_val = 64'd8;
        MemRead = 1; MemtoReg = 1; RegWrite = 1; rd_in = 5'd9;
        flush = 1; stall = 1;
        tick();
        check("flush MemRead", MemRead_store, 64'd0);
        check("flush valid", valid_store, 64'd0);
        check("flush target", branch_target, 64'h10);
        stall = 0;
        branch(3'b000, 64'd4, 64'd4, 64'h400, 64'h2);
        tick();
        check("flushed branch pc_src", pc_src, 64'd0);
        check("flushed branch squashing", squashing, 64'd0);
        flush = 0;
        nop();
        valid_in = 1; ALU_op = 2'd0; ALUsrc = 1; readdata1 = 64'h1000; immgen_val = 64'd8;
        MemRead = 1; MemtoReg = 1; RegWrite = 1; rd_in = 5'd9;
        tick();
        check("ld MemRead", MemRead_store, 64'd1);
        check("ld address", alu_result_store, 64'h1008);

        // flush during squash also counts down
        branch(3'b000, 64'd1, 64'd1, 64'h500, 64'h0);
        tick();
        flush = 1;
        tick();
        check("flush in squash", squashing, 64'd1);
        flush = 0;
        rtype(2'd2, 4'b0111, 64'hFF, 64'h0F, 0, 64'd0);
        tick();
        check("squash done", squashing, 64'd0);
        tick();
        check("and result", alu_result_store, 64'h0F);
        nop();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
